// File: rtl/counter_pkg.sv
// Shared definitions for the loadable up-counter and its sequencing controller.
// The defaults here match the team's standard 4-bit counter instance.
package counter_pkg;

  localparam int              DEF_WIDTH    = 4;
  localparam logic [3:0]      DEF_TERMINAL = 4'hF;
  localparam int              DEF_RWIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// Request channel from a host or FSM into counter_ctrl.
// valid/ready: the requester holds valid, data and repeat stable until a cycle
// with valid && ready, which is the single accept; ready never depends on valid.
interface counter_ctrl_if #(
  parameter int WIDTH = counter_pkg::DEF_WIDTH
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic [WIDTH-1:0] i_req_data;
  logic             i_req_repeat;

  modport master (
    output i_req_valid,
    output i_req_data,
    output i_req_repeat,
    input  o_req_ready
  );

  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_req_repeat,
    output o_req_ready
  );
endinterface

// File: rtl/counter_ctrl.sv
// Sequencer for one loadable up-counter: loads a start value, detects the
// terminal count, reports completed periods and optionally reloads.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TERMINAL = {WIDTH{1'b1}},
  parameter int               RWIDTH   = DEF_RWIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  counter_ctrl_if.slave     req,
  input  logic              i_stop,
  input  logic              i_abort,
  output logic              o_load,
  output logic [WIDTH-1:0]  o_data,
  input  logic [WIDTH-1:0]  i_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [RWIDTH-1:0] o_rounds,
  output logic [1:0]        o_state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;

  logic [1:0] state;
  logic       rpt;
  logic       accept;
  logic       terminal;

  // Ready and load are pure state decodes so no input reaches an output.
  assign req.o_req_ready = (state == S_IDLE);
  assign o_load          = (state == S_LOAD);
  assign o_busy          = (state != S_IDLE);
  assign o_state         = state;

  assign accept   = (state == S_IDLE) && req.i_req_valid;
  assign terminal = (i_count == TERMINAL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      rpt       <= 1'b0;
      o_data    <= '0;
      o_done    <= 1'b0;
      o_aborted <= 1'b0;
      o_rounds  <= '0;
    end else begin
      o_done    <= 1'b0;
      o_aborted <= 1'b0;
      if (i_stop) rpt <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            o_data   <= req.i_req_data;
            rpt      <= req.i_req_repeat;
            o_rounds <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            o_aborted <= 1'b1;
            state     <= S_IDLE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort outranks a terminal count on the same cycle.
          if (i_abort) begin
            o_aborted <= 1'b1;
            state     <= S_IDLE;
          end else if (terminal) begin
            o_done <= 1'b1;
            if (o_rounds != {RWIDTH{1'b1}}) o_rounds <= o_rounds + 1'b1;
            state <= (rpt && !i_stop) ? S_LOAD : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencer for the team's 4-bit loadable up-counter (ports i_clk, i_rst_n, i_load, i_data, o_counter).
- Accepts a timing request over a valid/ready handshake and drives the counter's load port with the requested start value. It then watches the count for the terminal value, reports each completed period, and optionally reloads for periodic operation.
- Sits between a host/FSM requester and one counter instance. It is the only driver of that counter's i_load and i_data.

Parameters:
- WIDTH, 4, width of counter value, request data and count feedback.
- TERMINAL, 4'hF (all ones at WIDTH), count value that ends a period.
- RWIDTH, 8, width of the completed-period counter o_rounds.

Ports:
- i_clk  in  1  rising-edge clock shared with the counter.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  requester presents a job.
- o_req_ready  out  1  high only in IDLE; a job is accepted on a cycle with valid&&ready.
- i_req_data  in  WIDTH  start value loaded into the counter.
- i_req_repeat  in  1  1 = reload automatically after every period; 0 = single shot.
- i_stop  in  1  graceful stop: clears the repeat flag, so the current period completes and then returns to IDLE.
- i_abort  in  1  immediate cancel.
- o_load  out  WIDTH-independent 1  to counter i_load.
- o_data  out  WIDTH  to counter i_data.
- i_count  in  WIDTH  from counter o_counter.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse per completed period.
- o_aborted  out  1  one-cycle pulse when an abort takes effect.
- o_rounds  out  RWIDTH  completed periods since the last accepted job, saturating.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE, o_load=0, o_data=0, o_done=0, o_aborted=0, o_rounds=0, repeat flag=0.
  - o_req_ready=1 after reset.
- Counter model:
  - o_load sampled high at an edge makes the counter equal i_data after that edge.
  - Otherwise the counter increments by 1 each edge, wrapping mod 2^WIDTH.
- FSM states: IDLE, LOAD, RUN. All outputs are registered or decoded from state, with no combinational path from inputs to outputs.
- IDLE:
  - o_req_ready=1.
  - On valid&&ready: capture data into o_data and repeat into the flag, clear o_rounds, go to LOAD.
- LOAD:
  - Exactly one cycle with o_load=1 and o_data=captured value.
  - Then go to RUN.
- RUN:
  - o_load=0.
  - When i_count==TERMINAL, the period ends. o_done=1 in the next cycle and o_rounds increments (saturates at all ones).
  - Next state is LOAD if the repeat flag is set, else IDLE.
- Latency and period:
  - Accept to o_load: 1 cycle.
  - The first RUN cycle sees i_count=start value.
  - RUN lasts TERMINAL-data+1 cycles.
  - In repeat mode, consecutive o_done pulses are TERMINAL-data+2 cycles apart.
  - data==TERMINAL gives a 1-cycle RUN.
- i_stop: clears the repeat flag in any state (no effect in IDLE). When asserted on the terminal cycle itself, the FSM goes to IDLE.
- i_abort:
  - In LOAD or RUN: go to IDLE next cycle, with o_aborted=1 that cycle and o_load=0.
  - Abort wins over a simultaneous terminal detect: no o_done and no o_rounds increment.
  - Ignored in IDLE.
- A request presented while busy is held off (ready=0). No request is ever dropped or queued.
- o_data keeps its last value in IDLE.

Decomposition:
- Package counter_pkg holds:
  - state enum (IDLE, LOAD, RUN);
  - default WIDTH and TERMINAL constants shared with the counter;
  - the RWIDTH default.
- No sub-module in the controller itself.
- The bench-level wrapper counter_timer instantiates counter_ctrl plus counter and is the natural integration unit.

Test Plan:
- Reset then single shot: rst_n low 20 ns; data=9, repeat=0 -> ready=1 after reset; o_load for 1 cycle; RUN sees 9..15 (7 cycles); o_done once; o_rounds=1; back to IDLE.
- Repeat mode: data=12, repeat=1 -> o_done every 5 cycles; after 4 pulses o_rounds=4; o_load pulses between periods.
- Stop: i_stop pulsed mid-period in repeat job -> current period finishes, one more o_done, then IDLE, no further o_load.
- Abort collision: i_abort on the cycle i_count==15 -> o_aborted=1, o_done stays 0, o_rounds unchanged, IDLE next cycle.
- Boundary and hold-off: data=15 gives a 1-cycle RUN and immediate o_done. valid held while busy -> ready=0 and no capture until IDLE, then accepted.
- Async reset mid-RUN: all outputs reset with no wait for a clock edge; the next request behaves as after a fresh reset.
